// File: rtl/tanh_drive_feeder.sv
// Drive-gain and saturation stage feeding the tanh soft-clipper, one sample in flight.
// Optional build macro DRIVE_SLEW_EN: slews an internal effective drive toward the drive port.
module tanh_drive_feeder #(
  parameter int DRIVE_FRAC_BITS = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_in_valid,
  input  logic [7:0]  drive,
  output logic [15:0] tanh_din,
  output logic        tanh_din_valid,
  input  logic        tanh_dout_valid,
  output logic        busy,
  output logic [15:0] overrun_count,
  output logic        timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MULT  = 3'd1,
    S_SAT   = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        sample_q, sample_d;
  logic [7:0]         drive_q, drive_d;
  logic signed [24:0] product_q, product_d;
  logic [15:0]        din_q, din_d;
  logic               din_valid_q, din_valid_d;
  logic               busy_q, busy_d;
  logic [15:0]        pend_q, pend_d;
  logic               pend_valid_q, pend_valid_d;
  logic [15:0]        tcnt_q, tcnt_d;
  logic [15:0]        overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  logic               load_s;
  logic [15:0]        load_sample_s;
  logic               consume_s;
  logic               take_direct_s;
  logic               wait_exit_s;
  logic               timeout_hit_s;
  logic [7:0]         accept_drive_s;
  logic signed [24:0] scaled_s;
  logic [15:0]        sat_s;

  function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) begin
      slew_step = cur + 8'd1;
    end else if (cur > tgt) begin
      slew_step = cur - 8'd1;
    end else begin
      slew_step = cur;
    end
  endfunction

`ifdef DRIVE_SLEW_EN
  logic [7:0] eff_drive_q, eff_drive_d;
  assign accept_drive_s = slew_step(eff_drive_q, drive);
`else
  assign accept_drive_s = drive;
`endif

  // Arithmetic shift floors toward -inf; the clamp is symmetric so -32768 never leaves.
  assign scaled_s = product_q >>> DRIVE_FRAC_BITS;
  always_comb begin
    if (scaled_s > 25'sd32767) begin
      sat_s = 16'h7FFF;
    end else if (scaled_s < -25'sd32767) begin
      sat_s = 16'h8001;
    end else begin
      sat_s = scaled_s[15:0];
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d       = state_q;
    sample_d      = sample_q;
    drive_d       = drive_q;
    product_d     = product_q;
    din_d         = din_q;
    din_valid_d   = 1'b0;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    tcnt_d        = tcnt_q;
    overrun_d     = overrun_q;
    timeout_d     = timeout_q;
    load_s        = 1'b0;
    load_sample_s = sample_in;
    consume_s     = 1'b0;
    take_direct_s = 1'b0;
    wait_exit_s   = 1'b0;
    timeout_hit_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sample_in_valid) begin
          load_s  = 1'b1;
          state_d = S_MULT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MULT: begin
        product_d = $signed({{9{sample_q[15]}}, sample_q} * {17'd0, drive_q});
        state_d   = S_SAT;
      end
      S_SAT: begin
        din_d   = sat_s;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        din_valid_d = 1'b1;
        tcnt_d      = 16'd0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d        = tcnt_q + 16'd1;
        timeout_hit_s = (tcnt_q + 16'd1) >= 16'(TIMEOUT_CYCLES);
        wait_exit_s   = tanh_dout_valid || timeout_hit_s;
        if (!tanh_dout_valid && timeout_hit_s) begin
          timeout_d = 1'b1;
        end else begin
          timeout_d = timeout_q;
        end
        if (!wait_exit_s) begin
          state_d = S_WAIT;
        end else if (pend_valid_q) begin
          // Pending sample goes out with whatever drive is current now.
          load_s        = 1'b1;
          load_sample_s = pend_q;
          consume_s     = 1'b1;
          state_d       = S_MULT;
        end else if (sample_in_valid) begin
          load_s        = 1'b1;
          take_direct_s = 1'b1;
          state_d       = S_MULT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_s) begin
      sample_d = load_sample_s;
      drive_d  = accept_drive_s;
    end else begin
      sample_d = sample_q;
    end

    // Samples arriving while busy land in the pending slot, latest wins.
    if ((state_q != S_IDLE) && sample_in_valid && !take_direct_s) begin
      pend_d       = sample_in;
      pend_valid_d = 1'b1;
      if (pend_valid_q && !consume_s && (overrun_q != 16'hFFFF)) begin
        overrun_d = overrun_q + 16'd1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (consume_s) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    busy_d = (state_d != S_IDLE);
  end

`ifdef DRIVE_SLEW_EN
  // Effective drive advances one LSB per sample entering MULT.
  always_comb begin
    if (load_s) begin
      eff_drive_d = accept_drive_s;
    end else begin
      eff_drive_d = eff_drive_q;
    end
  end

  // Effective drive register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eff_drive_q <= 8'(1 << DRIVE_FRAC_BITS);
    end else begin
      eff_drive_q <= eff_drive_d;
    end
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sample_q     <= 16'd0;
      drive_q      <= 8'd0;
      product_q    <= 25'sd0;
      din_q        <= 16'd0;
      din_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      pend_q       <= 16'd0;
      pend_valid_q <= 1'b0;
      tcnt_q       <= 16'd0;
      overrun_q    <= 16'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      drive_q      <= drive_d;
      product_q    <= product_d;
      din_q        <= din_d;
      din_valid_q  <= din_valid_d;
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      tcnt_q       <= tcnt_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign tanh_din       = din_q;
  assign tanh_din_valid = din_valid_q;
  assign busy           = busy_q;
  assign overrun_count  = overrun_q;
  assign timeout_flag   = timeout_q;

endmodule
